// File: rtl/game_control_if.sv
// Player keys, draw handshakes and one-hot datapath commands for the game sequencer.
// master: the sequencer side. slave: the board/datapath side.
interface game_control_if;
    logic key_up, key_down, key_left, key_right, key_attack;
    logic draw_map_done, draw_link_done;
    logic init, idle, attack, up, down, left, right, draw_map, draw_link;
    logic frame_tick, timeout_err;

    modport master (
        input  key_up, key_down, key_left, key_right, key_attack,
        input  draw_map_done, draw_link_done,
        output init, idle, attack, up, down, left, right, draw_map, draw_link,
        output frame_tick, timeout_err
    );

    modport slave (
        output key_up, key_down, key_left, key_right, key_attack,
        output draw_map_done, draw_link_done,
        input  init, idle, attack, up, down, left, right, draw_map, draw_link,
        input  frame_tick, timeout_err
    );
endinterface

// File: rtl/game_control.sv
// Game sequencer: keys + frame tick -> one-hot datapath commands, holding draws until done.
// Optional draw watchdog with sticky timeout_err: define GAME_CONTROL_TIMEOUT_EN.
module game_control #(
    parameter int FRAME_DIV      = 833333,
    parameter int ATTACK_FRAMES  = 16,
    parameter int TIMEOUT_CYCLES = 262144
) (
    input  logic           clock,
    input  logic           reset,
    game_control_if.master bus
);
    localparam int FW = $clog2(FRAME_DIV);
    localparam int AW = $clog2(ATTACK_FRAMES + 1);

    if (FRAME_DIV < 2 || ATTACK_FRAMES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("game_control: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_START, S_INIT, S_DRAW_MAP, S_DRAW_LINK, S_IDLE, S_MOVE, S_ATTACK
    } state_e;
    typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_e;

    state_e        state_q, state_d;
    dir_e          dir_q, dir_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [AW-1:0] atk_q, atk_d;
    logic          pend_q, pend_d;
    logic [4:0]    sync1_q, sync2_q;   // {attack, up, down, left, right}
    logic          tick, consume, tmo_hit;

    assign tick    = (frame_q == FW'(FRAME_DIV - 1));
    assign frame_d = tick ? '0 : frame_q + 1'b1;
    // A new tick wins over consumption of the old one; no queueing beyond one.
    assign pend_d  = tick | (pend_q & ~consume);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_START;
            dir_q   <= D_UP;
            frame_q <= '0;
            atk_q   <= '0;
            pend_q  <= 1'b0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            frame_q <= frame_d;
            atk_q   <= atk_d;
            pend_q  <= pend_d;
            sync1_q <= {bus.key_attack, bus.key_up, bus.key_down, bus.key_left, bus.key_right};
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        atk_d   = atk_q;
        consume = 1'b0;
        case (state_q)
            S_START:     state_d = S_INIT;
            S_INIT:      state_d = S_DRAW_MAP;
            S_DRAW_MAP:  if (bus.draw_map_done || tmo_hit) state_d = S_DRAW_LINK;
            S_DRAW_LINK: if (bus.draw_link_done || tmo_hit) state_d = S_IDLE;
            S_IDLE: begin
                if (pend_q) begin
                    consume = 1'b1;
                    if (sync2_q[4]) begin
                        state_d = S_ATTACK;
                        atk_d   = AW'(ATTACK_FRAMES);
                    end else if (sync2_q[3:0] != 4'b0) begin
                        state_d = S_MOVE;
                        if (sync2_q[3])      dir_d = D_UP;
                        else if (sync2_q[2]) dir_d = D_DOWN;
                        else if (sync2_q[1]) dir_d = D_LEFT;
                        else                 dir_d = D_RIGHT;
                    end
                end
            end
            S_MOVE:      state_d = S_DRAW_MAP;
            S_ATTACK: begin
                if (tick) begin
                    atk_d = atk_q - 1'b1;
                    if (atk_q <= AW'(1)) state_d = S_DRAW_MAP;
                end
            end
            default:     state_d = S_START;
        endcase
    end

`ifdef GAME_CONTROL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          terr_q, terr_d;
    logic          in_draw, draw_done;

    assign in_draw   = (state_q == S_DRAW_MAP) || (state_q == S_DRAW_LINK);
    assign draw_done = (state_q == S_DRAW_MAP) ? bus.draw_map_done : bus.draw_link_done;
    assign tmo_hit   = in_draw && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    // Restarts from zero on every entry into a draw state.
    assign tmo_d     = (in_draw && state_d == state_q) ? tmo_q + 1'b1 : '0;
    assign terr_d    = terr_q | (tmo_hit & ~draw_done);

    always_ff @(posedge clock) begin
        if (!reset) begin
            tmo_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            tmo_q  <= tmo_d;
            terr_q <= terr_d;
        end
    end

    assign bus.timeout_err = terr_q;
`else
    assign tmo_hit         = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.init       = (state_q == S_INIT);
    assign bus.idle       = (state_q == S_IDLE);
    assign bus.attack     = (state_q == S_ATTACK);
    assign bus.draw_map   = (state_q == S_DRAW_MAP);
    assign bus.draw_link  = (state_q == S_DRAW_LINK);
    assign bus.up         = (state_q == S_MOVE) && (dir_q == D_UP);
    assign bus.down       = (state_q == S_MOVE) && (dir_q == D_DOWN);
    assign bus.left       = (state_q == S_MOVE) && (dir_q == D_LEFT);
    assign bus.right      = (state_q == S_MOVE) && (dir_q == D_RIGHT);
    assign bus.frame_tick = tick;
endmodule

// File: doc/game_control.md
Name: game_control

Overview:
Top-level sequencer for the game datapath. It converts player key inputs and a frame-rate tick into the one-hot command strobes the datapath consumes (init, idle, attack, up/down/left/right, draw_map, draw_link). It holds each draw request until the matching done handshake returns, so map and Link never drive the VGA port at the same time. It sits between the board key inputs and the datapath.

Parameters:
FRAME_DIV, 833333, clock cycles per frame tick (60 Hz at 50 MHz); minimum 2.
ATTACK_FRAMES, 16, frame ticks the attack command is held; minimum 1.
TIMEOUT_CYCLES, 262144, draw watchdog limit (used only with the optional feature).

Ports:
clock  in  1  system clock (CLOCK_50)
reset  in  1  synchronous, active-low reset
key_up, key_down, key_left, key_right, key_attack  in  1 each  player inputs, active-high, asynchronous to clock
draw_map_done  in  1  datapath map draw complete
draw_link_done  in  1  datapath Link draw complete
init, idle, attack, up, down, left, right, draw_map, draw_link  out  1 each  commands to datapath; at most one high in any cycle
frame_tick  out  1  one-cycle pulse each frame
timeout_err  out  1  sticky draw-timeout flag (optional feature)

Behaviour:
- Reset: synchronous, active-low; sampled only on the rising edge of clock.
  - state <= S_START; frame counter, attack counter, tick_pending and synchronizers <= 0.
  - All outputs 0 while reset is low and in the first cycle after release.
- Key synchronizers: each key passes through a 2-flop synchronizer. A key change becomes visible to the FSM 2 cycles after its first sampling edge.
- Frame counter:
  - Free-running 0..FRAME_DIV-1; frame_tick = 1 in the cycle count == FRAME_DIV-1, then wraps to 0.
  - tick_pending is set by frame_tick and cleared when S_IDLE consumes it. A tick arriving while pending is already set is dropped (no queueing beyond one).
  - Set and clear in the same cycle: set wins.
- Outputs: a pure decode of the registered state (Moore); no combinational path from input to output.
- States and outputs:
  - S_START (all 0) -> S_INIT after 1 cycle.
  - S_INIT (init=1) -> S_DRAW_MAP after 1 cycle.
  - S_DRAW_MAP (draw_map=1): held until draw_map_done is sampled 1, then -> S_DRAW_LINK.
  - S_DRAW_LINK (draw_link=1): held until draw_link_done is sampled 1, then -> S_IDLE.
  - S_IDLE (idle=1): if tick_pending is 0, stay. If tick_pending is 1, clear it and decode synchronized keys, priority attack > up > down > left > right:
    - attack -> S_ATTACK, attack counter <= ATTACK_FRAMES.
    - direction -> S_MOVE, direction latched.
    - no key -> stay in S_IDLE (no redraw).
  - S_MOVE: latched direction output = 1 for exactly 1 cycle -> S_DRAW_MAP.
  - S_ATTACK (attack=1): decrement the counter on each frame_tick; when the counter reaches 0 -> S_DRAW_MAP. Keys are ignored while in S_ATTACK.
- Simultaneous direction keys resolve by the priority above; only one direction strobe per frame.
- A done signal already high on state entry is accepted on that entry cycle, giving a 1-cycle-minimum draw state.
- A done signal asserted outside its draw state is ignored.
- Reset asserted mid-draw or mid-attack: returns to S_START next edge; the pending tick is discarded.
- State encoding is free; unused encodings must recover to S_START.

Optional Feature:
Macro: GAME_CONTROL_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in S_DRAW_MAP and S_DRAW_LINK and is cleared on state entry.
  - If it reaches TIMEOUT_CYCLES without a done, the FSM advances as if done had been seen, and timeout_err is set.
  - timeout_err is sticky and cleared only by reset.
- Undefined: draw states wait indefinitely; timeout_err is tied to 0.

Test Plan:
1. Reset low 3 cycles, then high; datapath model returns draw_map_done after 100 cycles and draw_link_done after 50 -> outputs all 0, then init for exactly 1 cycle, draw_map high 100 cycles, draw_link high 50 cycles, then idle=1.
2. FRAME_DIV=10, in S_IDLE, key_right held -> at each consumed tick: right high exactly 1 cycle, then draw_map, then draw_link, then idle; never two outputs high together.
3. FRAME_DIV=10, key_up and key_left held together -> only up pulses; release key_up -> left pulses on the next frame.
4. ATTACK_FRAMES=3, FRAME_DIV=10, key_attack pulsed long enough to pass the synchronizer before a tick -> attack high for 3 frame ticks (~30 cycles), then the redraw sequence; direction keys during the attack produce no strobe.
5. Reset driven low while draw_map=1 and draw_map_done never returns -> draw_map drops after the next edge; the sequence restarts at S_START, then S_INIT.
6. GAME_CONTROL_TIMEOUT_EN defined, TIMEOUT_CYCLES=20, draw_map_done held 0 -> draw_map high 20 cycles, then draw_link; timeout_err=1 and stays 1 until reset.
